mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Arbitrates the single-ported unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the pipelined core.
- Sequences each access through a small FSM and drives registered memory-side request signals.
- Generates store byte enables and returns access completion to each requester.
- Provides anti-starvation for fetch and rejects misaligned data accesses.

Parameters:
- ADDR_W, 32, byte address width.
- MAX_STARVE, 4, consecutive data wins allowed while fetch waits; 1..15.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  fetch request; held with if_addr until if_valid.
- if_addr  in  ADDR_W  fetch address, word aligned.
- if_valid  out  1  fetch complete this cycle.
- if_rdata  out  32  instruction word, valid with if_valid.
- d_req  in  1  data request; held with d_* until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  size: 000 byte, 001 half, 010 word; others are illegal.
- d_addr  in  ADDR_W  byte address.
- d_wdata  in  32  store data, right-aligned.
- d_valid  out  1  data access complete this cycle.
- d_err  out  1  misaligned or illegal access; qualifies d_valid.
- d_rdata  out  32  raw aligned word read, valid with d_valid when d_err=0.
- m_req  out  1  memory request, registered.
- m_we  out  1  memory write, registered.
- m_addr  out  ADDR_W  word address, {d_addr[ADDR_W-1:2],2'b00}, registered.
- m_be  out  4  byte enables, registered; 4'b0000 on reads.
- m_wdata  out  32  lane-replicated store data, registered.
- m_ready  in  1  memory completes the access this cycle; may be high in the first m_req cycle.
- m_rdata  in  32  read word, valid with m_ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and starve_cnt to 0.
  - m_req, m_we, m_be, m_addr and m_wdata are all 0.
  - if_valid, d_valid and d_err are 0.
  - An in-flight access is abandoned with no completion pulse.
- States are IDLE, BUSY_IF, BUSY_D and ERR.
- Arbitration happens in IDLE only. Winner order:
  - d_req wins if set and starve_cnt < MAX_STARVE.
  - Otherwise if_req wins.
  - Otherwise the FSM stays in IDLE.
- Data grant:
  - Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or funct3 not in {000,001,010}.
  - Misaligned → ERR with no memory access.
  - Otherwise → BUSY_D.
- Fetch grant → BUSY_IF.
- On entering a BUSY state, m_req=1 and m_we/m_addr/m_be/m_wdata are loaded from the winning port.
- Byte enables and write data:
  - SB: m_be = 4'b0001 << addr[1:0], wdata byte replicated ×4.
  - SH: m_be = 4'b0011 << addr[1:0], wdata half replicated ×2.
  - SW: m_be = 4'b1111.
  - Loads: m_be = 0, m_we = 0.
- BUSY_x holds all m_* stable until m_ready=1.
  - On that cycle x_valid=1 combinationally and x_rdata=m_rdata.
  - At that edge the FSM → IDLE, m_req=0, and m_* → 0.
- ERR lasts one cycle with d_valid=1 and d_err=1, then → IDLE.
- Minimum access is 2 cycles of req→valid: the grant edge, then m_ready in the first BUSY cycle. One IDLE bubble separates accesses.
- Starvation counter:
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant.
  - Saturates at MAX_STARVE.
- Simultaneous d_req and if_req with starve_cnt = MAX_STARVE: fetch wins and data waits.
- Requests arriving during BUSY are not sampled until IDLE.
- Requesters deassert or change req only after their valid cycle. The arbiter never re-issues a completed access, because it only re-arbitrates in IDLE on the cycle after completion.
- if_addr[1:0] is ignored and treated as 00.
- m_ready while in IDLE or ERR is ignored.

Decomposition:
- Shared package/defines, alongside the existing opcode/funct3 defines:
  - state encoding (IDLE, BUSY_IF, BUSY_D, ERR);
  - funct3 size constants (F3_B, F3_H, F3_W).
- One natural sub-module, store_lane_gen: combinational, maps funct3, addr[1:0] and wdata to {be, lane wdata, misalign}.
- The FSM, starvation counter and output registers stay in the top module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, m_ready=1 on the first BUSY cycle.
  → m_req=1 and m_addr=0x100 one cycle after the request.
  → if_valid=1 with if_rdata=m_rdata in that BUSY cycle.
  → m_req=0 the next cycle.
- SB to 0x203 with d_wdata=0x000000AB, m_ready delayed 3 cycles.
  → m_be=1000, m_wdata=0xABABABAB and m_addr=0x200, all held for 3 cycles.
  → single d_valid pulse with d_err=0.
- SH to 0x201, and LW to 0x202.
  → each gives ERR: d_valid=1 and d_err=1 for one cycle, m_req never asserted.
  → funct3=011 gives the same result.
- Continuous d_req and if_req with MAX_STARVE=4, m_ready=1 always.
  → grant sequence D,D,D,D,IF repeating; starve_cnt returns to 0 after the IF grant.
- Reset asserted mid-BUSY_D with m_req=1.
  → m_req, m_be and the valids go to 0 immediately without waiting for clk.
  → after reset release, the next request is arbitrated from IDLE with starve_cnt=0.
- d_req only, m_ready=1 permanently.
  → one access every 2 cycles; exactly one d_valid per request handshake, no duplicate m_req.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM encoding, load/store
// size codes and the store lane bundle produced by store_lane_gen.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        ERR     = 2'd3
    } arb_state_t;

    localparam logic [2:0] F3_B = 3'b000;
    localparam logic [2:0] F3_H = 3'b001;
    localparam logic [2:0] F3_W = 3'b010;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        misalign;
    } lane_t;

endpackage

// File: rtl/mem_port_arbiter_store_lane_gen.sv
// Maps a data-port access (size, byte offset, right-aligned store data) onto
// memory byte enables and lane-replicated write data; flags illegal accesses.
module store_lane_gen
    import mem_port_arbiter_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output lane_t       lane
);

    always_comb begin
        lane = '0;
        case (funct3)
            F3_B: begin
                lane.be    = 4'b0001 << addr_lo;
                lane.wdata = {4{wdata[7:0]}};
            end
            F3_H: begin
                lane.misalign = addr_lo[0];
                lane.be       = 4'b0011 << addr_lo;
                lane.wdata    = {2{wdata[15:0]}};
            end
            F3_W: begin
                lane.misalign = |addr_lo;
                lane.be       = 4'b1111;
                lane.wdata    = wdata;
            end
            default: lane.misalign = 1'b1;
        endcase
        // Loads never drive byte enables or write data onto the bus.
        if (!we) begin
            lane.be    = '0;
            lane.wdata = '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported I/D memory between fetch and load/store, with
// fetch anti-starvation, registered memory requests and misalignment rejection.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_valid,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic              m_ready,
    input  logic [31:0]       m_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    arb_state_t state, state_nx;
    logic [3:0] starve_cnt;
    lane_t      lane;
    logic       d_win, i_win;
    logic       unused_if_lo;

    assign unused_if_lo = ^if_addr[1:0];

    store_lane_gen u_lane (
        .we      (d_we),
        .funct3  (d_funct3),
        .addr_lo (d_addr[1:0]),
        .wdata   (d_wdata),
        .lane    (lane)
    );

    assign if_rdata = m_rdata;
    assign d_rdata  = m_rdata;

    always_comb begin
        state_nx = state;
        d_win    = 1'b0;
        i_win    = 1'b0;
        if_valid = 1'b0;
        d_valid  = 1'b0;
        d_err    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (starve_cnt < STARVE_MAX)) begin
                    d_win    = 1'b1;
                    state_nx = lane.misalign ? ERR : BUSY_D;
                end else if (if_req) begin
                    i_win    = 1'b1;
                    state_nx = BUSY_IF;
                end
            end
            BUSY_IF: if (m_ready) begin
                if_valid = 1'b1;
                state_nx = IDLE;
            end
            BUSY_D: if (m_ready) begin
                d_valid  = 1'b1;
                state_nx = IDLE;
            end
            ERR: begin
                d_valid  = 1'b1;
                d_err    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_be       <= '0;
            m_wdata    <= '0;
        end else begin
            state <= state_nx;
            // Count data wins only while fetch is actually waiting.
            if (d_win && if_req && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
            else if (i_win)
                starve_cnt <= '0;

            if (d_win && !lane.misalign) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                m_be    <= lane.be;
                m_wdata <= lane.wdata;
            end else if (i_win) begin
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
                m_be    <= '0;
                m_wdata <= '0;
            end else if (if_valid || d_valid) begin
                m_req   <= 1'b0;
                m_we    <= 1'b0;
                m_addr  <= '0;
                m_be    <= '0;
                m_wdata <= '0;
            end
        end
    end

endmodule
